cook_timer: RTL and testbench

COOK_TIMER -- requirements
Module: cook_timer

---
 rtl/cook_timer.sv | 254 +++++++++++++++++++++++++
 tb/tb_cook_timer.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cook_timer.sv
// Kitchen cook timer: BCD MM:SS countdown driven by a 1 Hz tick, with
// add-time buttons, start/pause/cancel, door interlock and a done state.
module cook_timer #(
    parameter int unsigned QUICK_SEC = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz_in,
    input  logic       btn_add_min,
    input  logic       btn_add_10s,
    input  logic       btn_start,
    input  logic       btn_stop,
    input  logic       btn_clear,
    input  logic       door_open,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [1:0] state,
    output logic       running,
    output logic       done
);

    localparam logic [3:0] QuickTens = 4'(QUICK_SEC / 10);
    localparam logic [3:0] QuickOnes = 4'(QUICK_SEC % 10);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StPause = 2'd2,
        StDone  = 2'd3
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] min_tens_q, min_ones_q, sec_tens_q, sec_ones_q;
    logic [3:0] min_tens_d, min_ones_d, sec_tens_d, sec_ones_d;
    logic       running_q, done_q;
    logic       door_q;

    logic       sync1_q, sync2_q, sync3_q;
    logic       vld1_q, vld2_q, armed_q;
    logic       tick;
    logic       door_rise;
    logic       time_zero, time_one;

    // Results of the three time arithmetic operations.
    logic [3:0] a10_mt, a10_mo, a10_st, a10_so;
    logic [3:0] am_mt, am_mo, am_st, am_so;
    logic [3:0] dec_mt, dec_mo, dec_st, dec_so;

    // Synchronize the 1 Hz input and qualify edges; vld/armed stop an input that is
    // already high at reset release from counting as a rising edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
            vld1_q  <= 1'b0;
            vld2_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            sync1_q <= tick_1hz_in;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            vld1_q  <= 1'b1;
            vld2_q  <= vld1_q;
            armed_q <= armed_q | (vld2_q & ~sync2_q);
        end
    end

    assign tick      = armed_q & sync2_q & ~sync3_q;
    assign door_rise = door_open & ~door_q;

    assign time_zero = (min_tens_q == 4'd0) && (min_ones_q == 4'd0) &&
                       (sec_tens_q == 4'd0) && (sec_ones_q == 4'd0);
    assign time_one  = (min_tens_q == 4'd0) && (min_ones_q == 4'd0) &&
                       (sec_tens_q == 4'd0) && (sec_ones_q == 4'd1);

    // +10 seconds with carry into minutes, saturating at 99:59.
    always_comb begin
        a10_mt = min_tens_q;
        a10_mo = min_ones_q;
        a10_st = sec_tens_q;
        a10_so = sec_ones_q;
        if ((min_tens_q == 4'd9) && (min_ones_q == 4'd9) && (sec_tens_q == 4'd5)) begin
            a10_st = 4'd5;
            a10_so = 4'd9;
        end else if (sec_tens_q != 4'd5) begin
            a10_st = sec_tens_q + 4'd1;
        end else begin
            a10_st = 4'd0;
            if (min_ones_q == 4'd9) begin
                a10_mo = 4'd0;
                a10_mt = min_tens_q + 4'd1;
            end else begin
                a10_mo = min_ones_q + 4'd1;
            end
        end
    end

    // +1 minute, saturating at 99:59.
    always_comb begin
        am_mt = min_tens_q;
        am_mo = min_ones_q;
        am_st = sec_tens_q;
        am_so = sec_ones_q;
        if ((min_tens_q == 4'd9) && (min_ones_q == 4'd9)) begin
            am_st = 4'd5;
            am_so = 4'd9;
        end else if (min_ones_q == 4'd9) begin
            am_mo = 4'd0;
            am_mt = min_tens_q + 4'd1;
        end else begin
            am_mo = min_ones_q + 4'd1;
        end
    end

    // -1 second with BCD borrow; only used when time is nonzero.
    always_comb begin
        dec_mt = min_tens_q;
        dec_mo = min_ones_q;
        dec_st = sec_tens_q;
        dec_so = sec_ones_q;
        if (sec_ones_q != 4'd0) begin
            dec_so = sec_ones_q - 4'd1;
        end else if (sec_tens_q != 4'd0) begin
            dec_st = sec_tens_q - 4'd1;
            dec_so = 4'd9;
        end else begin
            dec_st = 4'd5;
            dec_so = 4'd9;
            if (min_ones_q != 4'd0) begin
                dec_mo = min_ones_q - 4'd1;
            end else begin
                dec_mo = 4'd9;
                dec_mt = min_tens_q - 4'd1;
            end
        end
    end

    // Next state and time; one prioritized event acts per cycle.
    always_comb begin
        state_d    = state_q;
        min_tens_d = min_tens_q;
        min_ones_d = min_ones_q;
        sec_tens_d = sec_tens_q;
        sec_ones_d = sec_ones_q;
        unique case (state_q)
            StIdle: begin
                if (btn_clear) begin
                    min_tens_d = 4'd0;
                    min_ones_d = 4'd0;
                    sec_tens_d = 4'd0;
                    sec_ones_d = 4'd0;
                end else if (btn_start && !door_open) begin
                    state_d = StRun;
                    if (time_zero) begin
                        sec_tens_d = QuickTens;
                        sec_ones_d = QuickOnes;
                    end
                end else if (btn_add_min) begin
                    min_tens_d = am_mt;
                    min_ones_d = am_mo;
                    sec_tens_d = am_st;
                    sec_ones_d = am_so;
                end else if (btn_add_10s) begin
                    min_tens_d = a10_mt;
                    min_ones_d = a10_mo;
                    sec_tens_d = a10_st;
                    sec_ones_d = a10_so;
                end
            end
            StRun: begin
                if (btn_clear) begin
                    state_d    = StIdle;
                    min_tens_d = 4'd0;
                    min_ones_d = 4'd0;
                    sec_tens_d = 4'd0;
                    sec_ones_d = 4'd0;
                end else if (btn_stop || door_open) begin
                    state_d = StPause;
                end else if (tick) begin
                    if (time_one) begin
                        state_d = StDone;
                    end
                    min_tens_d = dec_mt;
                    min_ones_d = dec_mo;
                    sec_tens_d = dec_st;
                    sec_ones_d = dec_so;
                end
            end
            StPause: begin
                if (btn_clear || btn_stop) begin
                    state_d    = StIdle;
                    min_tens_d = 4'd0;
                    min_ones_d = 4'd0;
                    sec_tens_d = 4'd0;
                    sec_ones_d = 4'd0;
                end else if (btn_start && !door_open) begin
                    state_d = StRun;
                end else if (btn_add_min) begin
                    min_tens_d = am_mt;
                    min_ones_d = am_mo;
                    sec_tens_d = am_st;
                    sec_ones_d = am_so;
                end else if (btn_add_10s) begin
                    min_tens_d = a10_mt;
                    min_ones_d = a10_mo;
                    sec_tens_d = a10_st;
                    sec_ones_d = a10_so;
                end
            end
            StDone: begin
                // Only a fresh door opening leaves DONE, not a door that was already open.
                if (btn_start || btn_stop || btn_clear || door_rise) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM state, time digits and registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            min_tens_q <= 4'd0;
            min_ones_q <= 4'd0;
            sec_tens_q <= 4'd0;
            sec_ones_q <= 4'd0;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
            door_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            min_tens_q <= min_tens_d;
            min_ones_q <= min_ones_d;
            sec_tens_q <= sec_tens_d;
            sec_ones_q <= sec_ones_d;
            running_q  <= (state_d == StRun);
            done_q     <= (state_d == StDone);
            door_q     <= door_open;
        end
    end

    assign min_tens = min_tens_q;
    assign min_ones = min_ones_q;
    assign sec_tens = sec_tens_q;
    assign sec_ones = sec_ones_q;
    assign state    = state_q;
    assign running  = running_q;
    assign done     = done_q;

endmodule

// File: tb/tb_cook_timer.sv
// Bench for cook_timer: directed scenarios plus random button/door/tick traffic,
// compared each cycle against a total-seconds reference model.
module tb_cook_timer;

    localparam int unsigned QUICK = 30;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick_1hz_in;
    logic       btn_add_min, btn_add_10s, btn_start, btn_stop, btn_clear;
    logic       door_open;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic [1:0] state;
    logic       running, done;
    logic [19:0] dut_vec;

    int total_cnt = 0;
    int bad_cnt   = 0;
    int cyc_no    = 0;

    // Reference model: state code, remaining time in whole seconds, tick-input history.
    int   m_st;
    int   m_secs;
    logic m_p1, m_p2, m_p3;
    logic m_door_prev;

    always #5 clk = ~clk;

    cook_timer #(.QUICK_SEC(QUICK)) dut (
        .clk        (clk),
        .reset      (reset),
        .tick_1hz_in(tick_1hz_in),
        .btn_add_min(btn_add_min),
        .btn_add_10s(btn_add_10s),
        .btn_start  (btn_start),
        .btn_stop   (btn_stop),
        .btn_clear  (btn_clear),
        .door_open  (door_open),
        .min_tens   (min_tens),
        .min_ones   (min_ones),
        .sec_tens   (sec_tens),
        .sec_ones   (sec_ones),
        .state      (state),
        .running    (running),
        .done       (done)
    );

    assign dut_vec = {state, running, done, min_tens, min_ones, sec_tens, sec_ones};

    function automatic logic [19:0] pack_time(input int st, input int secs);
        int mm;
        int ss;
        mm = secs / 60;
        ss = secs % 60;
        return {st[1:0], (st == 1), (st == 3), 4'(mm / 10), 4'(mm % 10),
                4'(ss / 10), 4'(ss % 10)};
    endfunction

    function automatic int sat(input int s);
        return (s > 5999) ? 5999 : s;
    endfunction

    task automatic check(input string tag, input logic [19:0] exp);
        total_cnt++;
        assert (dut_vec === exp)
        else begin
            bad_cnt++;
            $error("FAIL %s cycle=%0d: observed=%05h expected=%05h", tag, cyc_no, dut_vec, exp);
        end
    endtask

    task automatic model_reset();
        m_st        = 0;
        m_secs      = 0;
        // An input already high at release is treated as already seen.
        m_p1        = tick_1hz_in;
        m_p2        = tick_1hz_in;
        m_p3        = tick_1hz_in;
        m_door_prev = 1'b0;
    endtask

    // One clock edge of the reference model, using the inputs currently driven.
    task automatic model_edge();
        logic tk;
        // The time reacts two samples after the input is first seen high.
        tk   = m_p2 & ~m_p3;
        m_p3 = m_p2;
        m_p2 = m_p1;
        m_p1 = tick_1hz_in;
        case (m_st)
            0: begin
                if (btn_clear) m_secs = 0;
                else if (btn_start && !door_open) begin
                    if (m_secs == 0) m_secs = QUICK;
                    m_st = 1;
                end else if (btn_add_min) m_secs = sat(m_secs + 60);
                else if (btn_add_10s) m_secs = sat(m_secs + 10);
            end
            1: begin
                if (btn_clear) begin
                    m_st   = 0;
                    m_secs = 0;
                end else if (btn_stop || door_open) m_st = 2;
                else if (tk) begin
                    m_secs = m_secs - 1;
                    if (m_secs == 0) m_st = 3;
                end
            end
            2: begin
                if (btn_clear || btn_stop) begin
                    m_st   = 0;
                    m_secs = 0;
                end else if (btn_start && !door_open) m_st = 1;
                else if (btn_add_min) m_secs = sat(m_secs + 60);
                else if (btn_add_10s) m_secs = sat(m_secs + 10);
            end
            default: begin
                if (btn_start || btn_stop || btn_clear || (door_open && !m_door_prev)) m_st = 0;
            end
        endcase
        m_door_prev = door_open;
    endtask

    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
        cyc_no++;
        check("model", pack_time(m_st, m_secs));
        btn_add_min = 1'b0;
        btn_add_10s = 1'b0;
        btn_start   = 1'b0;
        btn_stop    = 1'b0;
        btn_clear   = 1'b0;
    endtask

    // 0=add_min 1=add_10s 2=start 3=stop 4=clear
    task automatic press(input int b);
        case (b)
            0: btn_add_min = 1'b1;
            1: btn_add_10s = 1'b1;
            2: btn_start   = 1'b1;
            3: btn_stop    = 1'b1;
            default: btn_clear = 1'b1;
        endcase
        cyc();
    endtask

    task automatic tick_sec();
        tick_1hz_in = 1'b1;
        repeat (3) cyc();
        tick_1hz_in = 1'b0;
        repeat (3) cyc();
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int tcnt;
        int r;
        logic [4:0] v;

        reset       = 1'b1;
        tick_1hz_in = 1'b0;
        btn_add_min = 1'b0;
        btn_add_10s = 1'b0;
        btn_start   = 1'b0;
        btn_stop    = 1'b0;
        btn_clear   = 1'b0;
        door_open   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", pack_time(0, 0));
        reset = 1'b0;
        model_reset();
        repeat (4) cyc();

        // 02:30 from adds, start, 31 ticks -> 01:59
        repeat (3) press(1);
        repeat (2) press(0);
        check("add_0230", pack_time(0, 150));
        press(2);
        check("start_0230", pack_time(1, 150));
        repeat (31) tick_sec();
        check("run_0159", pack_time(1, 119));

        // Count down to DONE and clear
        press(4);
        check("clear_run", pack_time(0, 0));
        press(2);
        check("quick_start", pack_time(1, QUICK));
        repeat (28) tick_sec();
        check("run_0002", pack_time(1, 2));
        tick_sec();
        check("run_0001", pack_time(1, 1));
        tick_sec();
        check("done_0000", pack_time(3, 0));
        press(4);
        check("done_clear", pack_time(0, 0));

        // Door opening on the same edge as a tick pauses without decrement
        press(2);
        check("quick_again", pack_time(1, 30));
        tick_1hz_in = 1'b1;
        repeat (2) cyc();
        door_open = 1'b1;
        cyc();
        check("door_pause", pack_time(2, 30));
        tick_1hz_in = 1'b0;
        press(2);
        check("start_door_open", pack_time(2, 30));
        repeat (2) cyc();
        door_open = 1'b0;
        cyc();
        press(2);
        check("resume", pack_time(1, 30));
        press(3);
        press(3);
        check("stop_stop", pack_time(0, 0));

        // Saturation at 99:59
        repeat (99) press(0);
        repeat (5) press(1);
        check("at_9950", pack_time(0, 5990));
        press(1);
        check("sat_10s_a", pack_time(0, 5999));
        press(1);
        check("sat_10s_b", pack_time(0, 5999));
        press(0);
        check("sat_min", pack_time(0, 5999));

        // Tick latency: three edges after the input rises, once per rising edge
        press(4);
        press(0);
        press(2);
        tick_1hz_in = 1'b1;
        cyc();
        check("lat_edge1", pack_time(1, 60));
        cyc();
        check("lat_edge2", pack_time(1, 60));
        cyc();
        check("lat_edge3", pack_time(1, 59));
        repeat (4) cyc();
        check("held_high", pack_time(1, 59));
        tick_1hz_in = 1'b0;
        repeat (4) cyc();
        check("falling", pack_time(1, 59));
        tick_sec();
        check("second_tick", pack_time(1, 58));

        // Asynchronous reset mid-RUN with the tick input held high
        press(4);
        repeat (5) press(0);
        press(2);
        check("run_0500", pack_time(1, 300));
        tick_1hz_in = 1'b1;
        reset = 1'b1;
        #1;
        check("async_abort", pack_time(0, 0));
        @(posedge clk);
        #1;
        check("reset_held", pack_time(0, 0));
        reset = 1'b0;
        model_reset();
        repeat (6) cyc();
        check("after_reset", pack_time(0, 0));
        press(0);
        press(2);
        repeat (6) cyc();
        check("no_stale_tick", pack_time(1, 60));
        tick_1hz_in = 1'b0;
        repeat (3) cyc();
        tick_sec();
        check("fresh_tick", pack_time(1, 59));

        // Random traffic against the model
        tcnt = 2;
        for (int i = 0; i < 2500; i++) begin
            r = int'($urandom_range(0, 999));
            if (r < 3) btn_clear = 1'b1;
            else if (r < 8) btn_stop = 1'b1;
            else if (r < 40) btn_start = 1'b1;
            else if (r < 45) btn_add_min = 1'b1;
            else if (r < 60) btn_add_10s = 1'b1;
            else if (r < 70) begin
                v = 5'($urandom_range(0, 31));
                btn_clear   = v[0];
                btn_stop    = v[1];
                btn_start   = v[2];
                btn_add_min = v[3];
                btn_add_10s = v[4];
            end
            if (door_open) begin
                if ($urandom_range(0, 999) < 200) door_open = 1'b0;
            end else begin
                if ($urandom_range(0, 999) < 5) door_open = 1'b1;
            end
            tcnt--;
            if (tcnt == 0) begin
                tick_1hz_in = ~tick_1hz_in;
                tcnt = int'($urandom_range(1, 3));
            end
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
